// File: rtl/fifo_pkg.sv
// Shared constants and the read-sequencer state type for the FIFO read stage.
package fifo_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
    localparam int PTR_W  = $clog2(DEPTH) + 1;
    localparam int ADDR_W = PTR_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } rd_state_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port.
// A same-address, same-cycle write and read returns the old word, because
// the read register samples the array before the write lands.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage write; the array itself is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, cleared by reset so the output word starts at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_rd_stage.sv
// Read-side data stage: owns storage, issues one read request at a time to
// the pointer controller and buffers the returned word for a valid/ready
// consumer.
//
// state | meaning
// IDLE  | nothing outstanding, waiting for the FIFO to become non-empty
// REQ   | rd pulse is on the wire this cycle
// WAIT  | request issued, controller has not yet qualified it
// HOLD  | out_data holds a word the consumer has not taken
module fifo_rd_stage #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int PTR_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_ptr,
    input  logic              rd_en,
    input  logic [PTR_W-1:0]  rd_ptr,
    input  logic              emp,
    input  logic              underflow,
    output logic              rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err
);

    import fifo_pkg::*;

    localparam int MEM_AW = PTR_W - 1;

    rd_state_t state;
    logic      capture;
    logic      unused_ptr_msb;

    // The pointer MSB only distinguishes laps; addressing ignores it.
    assign unused_ptr_msb = wr_ptr[PTR_W-1] ^ rd_ptr[PTR_W-1];

    // Only accept a returned word while a request is outstanding, so a held
    // word can never be overwritten under backpressure.
    assign capture = rd_en && ((state == REQ) || (state == WAIT));

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[MEM_AW-1:0]),
        .wr_data (wr_data),
        .rd_en   (capture),
        .rd_addr (rd_ptr[MEM_AW-1:0]),
        .rd_data (out_data)
    );

    // Read sequencer with registered rd / out_valid / err outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rd        <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (!emp) begin
                        state <= REQ;
                        rd    <= 1'b1;
                    end
                end
                REQ, WAIT: begin
                    // rd_en takes priority over a coincident underflow.
                    if (rd_en) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end else if (underflow) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!emp) begin
                            state <= REQ;
                            rd    <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_stage.sv
// Directed bench for fifo_rd_stage with a small pointer-controller model and
// a scoreboard of expected output words.
module tb_fifo_rd_stage;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
    localparam int PTR_W  = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_ptr;
    logic              rd_en;
    logic [PTR_W-1:0]  rd_ptr;
    logic              emp;
    logic              underflow;
    logic              rd;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              err;

    always #5 clk = ~clk;

    fifo_rd_stage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .wr_ptr    (wr_ptr),
        .rd_en     (rd_en),
        .rd_ptr    (rd_ptr),
        .emp       (emp),
        .underflow (underflow),
        .rd        (rd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    int               n_chk = 0;
    int               n_pass = 0;
    logic [DATA_W-1:0] mdl [DEPTH];
    logic [DATA_W-1:0] sb [$];
    logic [PTR_W-1:0]  wp, rp;
    bit               auto_rd, hold_emp, force_uf;
    bit               gap_chk, seq_chk;
    int               rd_pulses, xfers, cyc_n, last_xfer, gap_bad, seq_next;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: drive controller-model inputs, clock, update model, score.
    task automatic cyc();
        bit                xfer;
        logic [DATA_W-1:0] seen;
        wr_ptr    = wp;
        rd_ptr    = rp;
        emp       = hold_emp || (wp == rp);
        underflow = force_uf;
        rd_en     = auto_rd && rd && !emp;
        xfer      = out_valid && out_ready;
        seen      = out_data;
        if (rd) rd_pulses++;
        @(posedge clk);
        cyc_n++;
        if (!rst) begin
            wp = '0;
            rp = '0;
            sb.delete();
        end else begin
            if (xfer) begin
                xfers++;
                if (gap_chk && last_xfer >= 0 && (cyc_n - last_xfer) != 2) gap_bad++;
                last_xfer = cyc_n;
                if (sb.size() == 0) begin
                    n_chk++;
                    $error("FAIL sb_underrun observed=%0h expected=queued_word", seen);
                end else begin
                    chk("sb_data", seen, sb.pop_front());
                end
                if (seq_chk) begin
                    chk("wrap_seq", seen, seq_next);
                    seq_next++;
                end
            end
            if (rd_en) begin
                sb.push_back(mdl[rp[PTR_W-2:0]]);
                rp++;
            end
            if (wr_en) begin
                mdl[wp[PTR_W-2:0]] = wr_data;
                wp++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bit stable;
        rst = 1'b0; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0;
        auto_rd = 1'b1; hold_emp = 1'b0; force_uf = 1'b0;
        gap_chk = 1'b0; seq_chk = 1'b0; seq_next = 0;
        wp = '0; rp = '0; rd_pulses = 0; xfers = 0; cyc_n = 0; last_xfer = -1; gap_bad = 0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            wr_data   = DATA_W'($urandom);
            out_ready = 1'($urandom);
            force_uf  = 1'($urandom);
            hold_emp  = 1'($urandom);
            cyc();
            chk("rst_rd", rd, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
            chk("rst_err", err, 0);
        end
        force_uf = 1'b0; hold_emp = 1'b0; out_ready = 1'b0;
        rst = 1'b1;

        // Single word, zero-wait read
        rd_pulses = 0; xfers = 0; out_ready = 1'b1;
        wr_en = 1'b1; wr_data = 8'hA5; cyc(); wr_en = 1'b0;
        chk("single_idle_rd", rd, 0);
        cyc();
        chk("single_rd", rd, 1);
        chk("single_early_valid", out_valid, 0);
        cyc();
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8'hA5);
        chk("single_rd_drop", rd, 0);
        repeat (4) cyc();
        chk("single_xfers", xfers, 1);
        chk("single_rd_pulses", rd_pulses, 1);
        chk("single_idle_valid", out_valid, 0);
        chk("single_sb_left", sb.size(), 0);

        // Backpressure: 32 writes while consumer stalls
        out_ready = 1'b0; rd_pulses = 0;
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_data = DATA_W'(i); cyc();
        end
        wr_en = 1'b0;
        stable = 1'b1;
        repeat (20) begin
            cyc();
            if (out_data !== 8'h00 || out_valid !== 1'b1) stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        chk("bp_one_rd", rd_pulses, 1);
        chk("bp_data0", out_data, 0);
        out_ready = 1'b1; xfers = 0; gap_chk = 1'b1; last_xfer = -1; gap_bad = 0;
        for (int n = 0; n < 200 && xfers < 32; n++) cyc();
        gap_chk = 1'b0;
        chk("bp_xfers", xfers, 32);
        repeat (6) cyc();
        chk("bp_rd_total", rd_pulses, 32);
        chk("bp_gap", gap_bad, 0);
        chk("bp_end_valid", out_valid, 0);

        // Wrap: restart pointers at 0 and stream 40 words through
        rst = 1'b0; cyc(); rst = 1'b1;
        xfers = 0; seq_chk = 1'b1; seq_next = 0; out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b1; wr_data = DATA_W'(i); cyc();
        end
        wr_en = 1'b0;
        for (int n = 0; n < 200 && xfers < 40; n++) cyc();
        seq_chk = 1'b0;
        chk("wrap_xfers", xfers, 40);
        chk("wrap_sb_left", sb.size(), 0);

        // Underflow in WAIT
        auto_rd = 1'b0;
        wr_en = 1'b1; wr_data = 8'h5A; cyc(); wr_en = 1'b0;
        cyc();
        chk("uf_req_rd", rd, 1);
        cyc();
        chk("uf_wait_rd", rd, 0);
        chk("uf_wait_valid", out_valid, 0);
        force_uf = 1'b1; cyc(); force_uf = 1'b0; hold_emp = 1'b1;
        chk("uf_err", err, 1);
        chk("uf_valid", out_valid, 0);
        chk("uf_idle_rd", rd, 0);
        repeat (5) cyc();
        chk("uf_err_sticky", err, 1);
        chk("uf_no_rd", rd, 0);

        // Reset while holding an unaccepted word
        rst = 1'b0; cyc(); rst = 1'b1;
        hold_emp = 1'b0; auto_rd = 1'b1; out_ready = 1'b0;
        chk("mh_err_clr", err, 0);
        wr_en = 1'b1; wr_data = 8'hC3; cyc(); wr_en = 1'b0;
        for (int n = 0; n < 10 && out_valid !== 1'b1; n++) cyc();
        chk("mh_valid", out_valid, 1);
        chk("mh_data", out_data, 8'hC3);
        rst = 1'b0; cyc(); rst = 1'b1;
        chk("mh_rst_valid", out_valid, 0);
        chk("mh_rst_rd", rd, 0);
        chk("mh_rst_data", out_data, 0);
        rd_pulses = 0;
        repeat (5) cyc();
        chk("mh_after_valid", out_valid, 0);
        chk("mh_after_rd", rd_pulses, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stage.md
# fifo_rd_stage

Read-side data stage that sits directly downstream of the `fifo` pointer/flag controller. It holds the 32-entry storage array, written at the controller's `wr_ptr` whenever `wr_en` fires. It drains entries by issuing `rd` requests to the controller, captures the word addressed by `rd_ptr` when `rd_en` fires, and presents it to the consumer over a valid/ready handshake. The block owns storage, read sequencing and output buffering; full/empty/overflow/underflow decisions stay in `fifo`.

## Interface

Parameters:
- `DATA_W`, 8: data word width.
- `DEPTH`, 32: number of entries; must be a power of two.
- `PTR_W`, 6: pointer width, `$clog2(DEPTH)+1`. The MSB is the wrap bit; the low bits form the address.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-low reset.
- `wr_data`  in  DATA_W  write word, valid with `wr_en`.
- `wr_en`  in  1  qualified write from `fifo`.
- `wr_ptr`  in  PTR_W  write pointer from `fifo`.
- `rd_en`  in  1  qualified read from `fifo`.
- `rd_ptr`  in  PTR_W  read pointer from `fifo`, pre-increment in the `rd_en` cycle.
- `emp`  in  1  empty flag from `fifo`.
- `underflow`  in  1  underflow flag from `fifo`.
- `rd`  out  1  registered read request to `fifo`, one-cycle pulse.
- `out_data`  out  DATA_W  registered output word.
- `out_valid`  out  1  `out_data` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `err`  out  1  sticky flag: an underflow was seen during a request.

## Operation

- **Storage:** if `wr_en` is high at posedge, `mem[wr_ptr[PTR_W-2:0]] <= wr_data`. The array is not reset.
- **Read capture:** if `rd_en` is high at posedge, `out_data <= mem[rd_ptr[PTR_W-2:0]]`. This is read-before-write: on a same-address, same-cycle write, the pre-write word is captured.
- **States** (`rd_state_t`): IDLE, REQ, WAIT, HOLD.
  - IDLE: if `!emp`, go to REQ and drive `rd=1` for that cycle. Otherwise stay.
  - REQ: `rd=1` for exactly one cycle.
    - `rd_en`: capture, go to HOLD.
    - `underflow`: set `err`, go to IDLE.
    - Neither: go to WAIT.
  - WAIT: `rd=0`.
    - `rd_en`: capture, go to HOLD.
    - `underflow`: set `err`, go to IDLE.
  - HOLD: `out_valid=1`, `out_data` stable.
    - On `out_ready`:
      - `!emp`: go to REQ.
      - `emp`: go to IDLE.
    - Without `out_ready`, stay. No `rd` is issued while holding an unaccepted word.
- **Request limit:** at most one outstanding request. `rd` is never asserted outside REQ.
- **Simultaneous events:**
  - `rd_en` and `underflow` in the same cycle: `rd_en` wins.
  - `wr_en` and `rd_en` in the same cycle are independent.
- **`err`:** sticky; cleared only by reset.

## Timing

- **Reset values** (`rst==0` at posedge): state=IDLE, `rd=0`, `out_valid=0`, `out_data=0`, `err=0`.
- **Mid-operation reset:** discards any held or requested word. The next edge with `rst==1` resumes from IDLE.
- **Request timing:**
  - `emp` sampled low at edge k: `rd` is high during cycle k..k+1.
  - `fifo` asserts `rd_en` in that same cycle (zero-wait) or later (WAIT).
- **Latency:** zero-wait `rd_en` gives `out_valid=1` after edge k+1, i.e. 2 cycles from `emp` falling.
- **Throughput:** 1 word per 2 cycles, with continuous `out_ready` and non-empty FIFO.
- **Handshake:** a transfer occurs on a posedge with `out_valid && out_ready`. `out_data` is held constant while `out_valid && !out_ready`.
- **Wrap-around:** the address ignores the pointer MSB, so pointer 32 addresses entry 0 (second lap).

## Structure

- **Package `fifo_pkg`:** `DEPTH`, `PTR_W`, `ADDR_W`, and enum `rd_state_t` (IDLE, REQ, WAIT, HOLD).
- **Sub-module `fifo_mem`:** simple dual-port array with a write port and a registered read port. It holds the read-before-write behaviour.
- **Top:** `fifo_rd_stage` contains the FSM, output register and `err`.

## Test plan

- **Reset:** hold `rst=0` for 2 cycles with random inputs -> `rd=0`, `out_valid=0`, `out_data=0`, `err=0`; no state change.
- **Single word:** write 0xA5 at `wr_ptr=0`; `fifo` drops `emp` and answers `rd` with zero-wait `rd_en`; `out_ready=1` -> one `rd` pulse, `out_valid=1` with `out_data=0xA5` 2 cycles after `emp` falls, then IDLE.
- **Backpressure:** write 0..31, hold `out_ready=0` for 20 cycles -> exactly one `rd`, `out_data=0x00` stable. Then set `out_ready=1` -> 0..31 delivered in order, one per 2 cycles, no `rd` after the last word.
- **Wrap:** 40 writes and 40 reads interleaved so pointers cross 31->32 -> words 32..39 read correctly from addresses 0..7; output sequence 0..39 is unbroken.
- **Underflow:** force `underflow=1` with no `rd_en` while in WAIT -> IDLE next cycle, `err=1` and stays 1, `out_valid=0`.
- **Reset mid-HOLD:** `rst=0` while `out_valid=1` and `out_ready=0` -> `out_valid=0`, `rd=0` after that edge; the word is dropped.
